// File: rtl/rmt_arb_pkg.sv
// rmt_arb_pkg: shared state encoding and sizing helpers for the packet arbiter
package rmt_arb_pkg;

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    localparam int MAX_PORTS = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// rr_select: rotate-priority encoder picking the first requester after last_grant
module rr_select #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last_grant,
    output logic         o_any_req,
    output logic [W-1:0] o_next_grant
);

    // scan farthest-first so the nearest requester after last_grant wins
    always_comb begin
        o_any_req    = |i_req;
        o_next_grant = i_last_grant;
        for (int k = N; k >= 1; k--)
            if (i_req[(int'(i_last_grant) + k) % N])
                o_next_grant = W'((int'(i_last_grant) + k) % N);
    end

endmodule

// File: rtl/rmt_pkt_arbiter.sv
// rmt_pkt_arbiter: packet-granular round-robin merge of AXI-Stream sources
module rmt_pkt_arbiter
    import rmt_arb_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS            = 2
) (
    input  logic                                           clk,
    input  logic                                           aresetn,
    input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                           s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                           s_axis_tlast,
    output logic [NUM_PORTS-1:0]                           s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]               m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]                m_axis_tuser,
    output logic                                           m_axis_tvalid,
    output logic                                           m_axis_tlast,
    input  logic                                           m_axis_tready,
    output logic [idx_width(NUM_PORTS)-1:0]                grant_id
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int GW = idx_width(NUM_PORTS);

    state_t          r_state, w_next_state;
    logic [GW-1:0]   r_grant, r_last_grant, w_next_grant;
    logic            w_any_req, w_ready, w_accept, w_last;
    logic [DW-1:0]   r_tdata;
    logic [KW-1:0]   r_tkeep;
    logic [UW-1:0]   r_tuser;
    logic            r_tvalid, r_tlast;

    rr_select #(.N(NUM_PORTS), .W(GW)) u_rr_select (
        .i_req        (s_axis_tvalid),
        .i_last_grant (r_last_grant),
        .o_any_req    (w_any_req),
        .o_next_grant (w_next_grant)
    );

    assign w_ready       = (r_state == ST_BUSY) && (!r_tvalid || m_axis_tready);
    assign w_accept      = w_ready && s_axis_tvalid[r_grant];
    assign w_last        = s_axis_tlast[r_grant];
    assign s_axis_tready = {{(NUM_PORTS-1){1'b0}}, w_ready} << r_grant;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign grant_id      = r_grant;

    // grant on any request when idle; release only when the tlast beat is taken
    always_comb begin
        w_next_state = r_state;
        if (r_state == ST_IDLE && w_any_req)
            w_next_state = ST_BUSY;
        else if (r_state == ST_BUSY && w_accept && w_last)
            w_next_state = ST_IDLE;
    end

    // state, grant and round-robin pointer; pointer starts at the top so port 0 wins first
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_PORTS - 1);
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && w_any_req)
                r_grant <= w_next_grant;
            if (w_accept && w_last)
                r_last_grant <= r_grant;
        end
    end

    // output skid-free register: load on accept, drop valid once drained, hold data
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tuser  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else if (w_accept) begin
            r_tdata  <= s_axis_tdata[int'(r_grant)*DW +: DW];
            r_tkeep  <= s_axis_tkeep[int'(r_grant)*KW +: KW];
            r_tuser  <= s_axis_tuser[int'(r_grant)*UW +: UW];
            r_tlast  <= w_last;
            r_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

endmodule

// File: doc/rmt_pkt_arbiter.md
# rmt_pkt_arbiter

Packet-granular round-robin arbiter that merges NUM_PORTS AXI-Stream sources (e.g. the filtered data path and a re-injected/control-generated path) onto the single AXI-Stream input of the RMT parser pipeline. A grant is held from the first beat to `tlast`, so packets are never interleaved. The output is a registered stage with full `tready` back-pressure.

## Interface
- `C_S_AXIS_DATA_WIDTH`, 512, tdata width per port; tkeep is width/8.
- `C_S_AXIS_TUSER_WIDTH`, 128, tuser width per port.
- `NUM_PORTS`, 2, number of input streams (2..8); port i occupies slice i of each flat vector.
- `clk`  in  1  single clock for all logic.
- `aresetn`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  NUM_PORTS*DW  per-port data.
- `s_axis_tkeep`  in  NUM_PORTS*DW/8  per-port byte enables.
- `s_axis_tuser`  in  NUM_PORTS*UW  per-port metadata.
- `s_axis_tvalid`  in  NUM_PORTS  per-port valid.
- `s_axis_tlast`  in  NUM_PORTS  per-port last.
- `s_axis_tready`  out  NUM_PORTS  per-port ready; at most one bit high.
- `m_axis_tdata/tkeep/tuser`  out  DW / DW/8 / UW  merged stream, registered.
- `m_axis_tvalid`, `m_axis_tlast`  out  1  merged valid/last, registered.
- `m_axis_tready`  in  1  downstream ready.
- `grant_id`  out  clog2(NUM_PORTS)  port currently/last granted (debug).

## Operation
- States: IDLE, BUSY. Reset: state = IDLE, `last_grant` = NUM_PORTS-1 (so port 0 wins first), all outputs 0.
- IDLE: if any `s_axis_tvalid` is high, select the first requesting port scanning `last_grant+1, +2, ...` modulo NUM_PORTS. Register it as `grant` and go to BUSY. No beat is accepted in the IDLE cycle and `s_axis_tready` stays all-zero.
- BUSY: `s_axis_tready[grant] = ~m_axis_tvalid | m_axis_tready`; all other ready bits are 0.
- Accept = valid & ready on the granted port. On accept, load the output register with that port's tdata/tkeep/tuser/tlast and set `m_axis_tvalid` = 1.
- Accept with tlast: return to IDLE and set `last_grant` = `grant`.
- Output register: if `m_axis_tready` is high and there is no accept in the same cycle, clear `m_axis_tvalid`; data fields are held. While `m_axis_tvalid & ~m_axis_tready`, all m_axis fields stay stable.
- The granted port deasserting tvalid mid-packet keeps the arbiter in BUSY with the grant held indefinitely; no timeout.
- Single-beat packet (tlast on the first beat): BUSY lasts one accept, then IDLE.
- Non-granted ports see ready = 0 and are never dropped. The filter's control output has no ready, so it must be buffered before reaching a port of this block.
- `grant_id` = `grant` register, reset to 0.

## Timing
- Arbitration costs one bubble per packet: tvalid seen in IDLE at cycle 0, first accept at cycle 1, `m_axis_tvalid` high at cycle 2.
- Steady state inside a packet: one beat per cycle when `m_axis_tready` is held high.
- Back-to-back packets: at least one idle output cycle between the tlast of one packet and the first beat of the next.
- Reset asserted mid-packet: everything returns to reset values immediately. The truncated packet is not completed, and downstream must tolerate a missing tlast after reset.
- Fairness: a port that requests continuously is granted within NUM_PORTS-1 packets.

## Structure
- Package `rmt_arb_pkg`:
  - state encoding (IDLE = 0, BUSY = 1);
  - `MAX_PORTS` = 8;
  - port-index width function (clog2).
- Sub-module `rr_select`: combinational rotate-priority encoder.
  - Inputs: request vector, `last_grant`.
  - Outputs: `any_req`, `next_grant`.
- Top level holds the FSM, the grant and last_grant registers, and the output register.

## Test plan
- Reset, then port 0 sends a 3-beat packet (tdata 0xA1, 0xA2, 0xA3, tlast on beat 3) with `m_axis_tready` = 1 -> output 0xA1 at cycle 2, 0xA3 with tlast at cycle 4, `grant_id` = 0.
- Both ports send a 2-beat packet simultaneously from reset -> port 0 packet first, then port 1. Port 1 `s_axis_tready` stays 0 until port 0 tlast is accepted, and there is no interleaving.
- Both ports request continuously, 4 single-beat packets each -> output port order 0,1,0,1,... and never two consecutive packets from the same port.
- `m_axis_tready` low for 3 cycles mid-packet -> m_axis fields unchanged, `s_axis_tready[grant]` = 0 while output is full, no beat lost or duplicated.
- Granted port drops tvalid for 5 cycles mid-packet while port 1 requests -> grant held, port 1 ready stays 0, and the packet resumes intact.
- `aresetn` pulsed low during beat 2 of 4 -> all outputs 0 and state IDLE the same cycle. The next request from port 1 is granted with `grant_id` = 1 when port 0 is idle.
